// File: rtl/rat_int_pkg.sv
// -----------------------------------------------------------------------------
// rat_int_pkg
// Shared types and constants for the RAT interrupt controller.
//   int_state_t    : controller FSM state encoding
//   *_PORT_DEF     : default IO port ids for the mask / status / EOI registers
//   STAT_*_BIT     : bit positions inside the status byte
//   WIN_W          : width of the winner id (supports up to 8 sources)
// Optional feature macro used by rat_int_ctrl: RAT_INT_EDGE_EN
// -----------------------------------------------------------------------------
package rat_int_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } int_state_t;

   localparam logic [7:0] MASK_PORT_DEF = 8'h20;
   localparam logic [7:0] STAT_PORT_DEF = 8'h21;
   localparam logic [7:0] EOI_PORT_DEF  = 8'h22;

   // Status byte layout: {in_service, requesting, 3'b0, win_id[2:0]}
   localparam int STAT_SVC_BIT = 7;
   localparam int STAT_REQ_BIT = 6;

   localparam int WIN_W = 3;

endpackage

// File: rtl/rat_prio_enc.sv
// -----------------------------------------------------------------------------
// rat_prio_enc
// Combinational lowest-index priority encoder.
// Ports:
//   req    in   N      request vector
//   valid  out  1      any request set
//   idx    out  WIN_W  index of the lowest set request (0 when none)
// -----------------------------------------------------------------------------
module rat_prio_enc
   import rat_int_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0]     req,
   output logic             valid,
   output logic [WIN_W-1:0] idx
);

   // Scan from the top down so the last hit, i.e. the lowest index, wins.
   always_comb begin
      // NOTE: every output gets a default before any conditional write, so no latch is inferred.
      valid = |req;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = WIN_W'(i);
      end
   end

endmodule

// File: rtl/rat_int_ctrl.sv
// -----------------------------------------------------------------------------
// rat_int_ctrl
// Prioritised interrupt controller feeding the RAT control unit's single
// interrupt input. Latches peripheral requests, masks them, selects the
// lowest-index eligible source and holds it through ACK until an EOI write.
//
// Ports:
//   CLK       in   1        system clock, rising edge
//   RESET     in   1        synchronous, active-high reset
//   SRC       in   NUM_SRC  raw interrupt sources, synchronous to CLK
//   I_FLAG    in   1        CPU global interrupt enable
//   INT_ACK   in   1        control unit has entered its interrupt cycle
//   PORT_ID   in   8        IO port address
//   OUT_PORT  in   8        IO write data
//   IO_STRB   in   1        IO write strobe
//   INT_REQ   out  1        interrupt request to the control unit
//   IN_DATA   out  8        read data for mask/status ports, else 8'h00
//   IN_HIT    out  1        PORT_ID addresses the mask or status register
//
// Build option:
//   RAT_INT_EDGE_EN  defined   -> sources pend on their rising edge only
//                    undefined -> sources pend every cycle they are high
// -----------------------------------------------------------------------------
module rat_int_ctrl
   import rat_int_pkg::*;
#(
   parameter int         NUM_SRC   = 8,
   parameter logic [7:0] MASK_PORT = MASK_PORT_DEF,
   parameter logic [7:0] STAT_PORT = STAT_PORT_DEF,
   parameter logic [7:0] EOI_PORT  = EOI_PORT_DEF
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [NUM_SRC-1:0] SRC,
   input  logic               I_FLAG,
   input  logic               INT_ACK,
   input  logic [7:0]         PORT_ID,
   input  logic [7:0]         OUT_PORT,
   input  logic               IO_STRB,
   output logic               INT_REQ,
   output logic [7:0]         IN_DATA,
   output logic               IN_HIT
);

   logic [NUM_SRC-1:0] pend;
   logic [NUM_SRC-1:0] mask;
   logic [NUM_SRC-1:0] set_vec;
   logic [NUM_SRC-1:0] clr_vec;
   logic [NUM_SRC-1:0] elig;

   int_state_t         state;
   int_state_t         next_state;
   logic [WIN_W-1:0]   win_id;
   logic [WIN_W-1:0]   win_nxt;
   logic               int_req_q;
   logic               int_req_nxt;

   logic               enc_valid;
   logic [WIN_W-1:0]   enc_idx;
   logic               win_elig;
   logic               mask_wr;
   logic               eoi_wr;

   assign mask_wr = IO_STRB && (PORT_ID == MASK_PORT);
   assign eoi_wr  = IO_STRB && (PORT_ID == EOI_PORT);

   // ---------------------------------------------------------------- capture
`ifdef RAT_INT_EDGE_EN
   logic [NUM_SRC-1:0] src_prev;

   always_ff @(posedge CLK) begin
      // NOTE: reset is sampled on the clock edge (synchronous), and sequential state uses <= only.
      if (RESET) src_prev <= '0;
      else       src_prev <= SRC;
   end

   assign set_vec = SRC & ~src_prev;
`else
   assign set_vec = SRC;
`endif

   // Decode win_id against the source vector. Done as a loop rather than
   // indexing so a win_id beyond NUM_SRC can never select a missing bit.
   always_comb begin
      clr_vec  = '0;
      win_elig = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (win_id == WIN_W'(i)) begin
            clr_vec[i] = (state == ST_REQ) && INT_ACK;
            win_elig   = elig[i];
         end
      end
   end

   // Set is OR-ed in after the clear so a same-cycle new request survives ACK.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pend <= '0;
         mask <= '0;
      end else begin
         pend <= (pend & ~clr_vec) | set_vec;
         if (mask_wr) mask <= OUT_PORT[NUM_SRC-1:0];
      end
   end

   assign elig = pend & mask;

   rat_prio_enc #(
      .N (NUM_SRC)
   ) u_prio_enc (
      .req   (elig),
      .valid (enc_valid),
      .idx   (enc_idx)
   );

   // ---------------------------------------------------------------- FSM
   always_comb begin
      next_state = state;
      win_nxt    = win_id;
      case (state)
         ST_IDLE: begin
            if (I_FLAG && enc_valid) begin
               next_state = ST_REQ;
               win_nxt    = enc_idx;
            end
         end
         // win_id stays frozen here: a later higher-priority arrival waits.
         ST_REQ: begin
            if (INT_ACK)                  next_state = ST_SERVICE;
            else if (!I_FLAG || !win_elig) next_state = ST_IDLE;
         end
         ST_SERVICE: begin
            if (eoi_wr) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
      // Registered request: raised one cycle after entering ST_REQ and
      // dropped on the same edge that leaves it.
      int_req_nxt = (state == ST_REQ) && (next_state == ST_REQ);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= ST_IDLE;
         win_id    <= '0;
         int_req_q <= 1'b0;
      end else begin
         state     <= next_state;
         win_id    <= win_nxt;
         int_req_q <= int_req_nxt;
      end
   end

   assign INT_REQ = int_req_q;

   // ---------------------------------------------------------------- IO read
   always_comb begin
      IN_DATA = '0;
      IN_HIT  = 1'b0;
      if (PORT_ID == MASK_PORT) begin
         IN_HIT                 = 1'b1;
         IN_DATA[NUM_SRC-1:0]   = mask;
      end else if (PORT_ID == STAT_PORT) begin
         IN_HIT                 = 1'b1;
         IN_DATA[STAT_SVC_BIT]  = (state == ST_SERVICE);
         IN_DATA[STAT_REQ_BIT]  = (state == ST_REQ);
         IN_DATA[WIN_W-1:0]     = win_id;
      end
   end

endmodule

// File: tb/tb_rat_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rat_int_ctrl
// Directed bench for rat_int_ctrl. Each expected interrupt is pushed to a
// scoreboard as the stimulus is driven, as the status byte the controller
// should show while requesting, and popped when INT_REQ rises.
// -----------------------------------------------------------------------------
module tb_rat_int_ctrl;

   localparam logic [7:0] MASK_P = 8'h20;
   localparam logic [7:0] STAT_P = 8'h21;
   localparam logic [7:0] EOI_P  = 8'h22;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [7:0] SRC;
   logic       I_FLAG;
   logic       INT_ACK;
   logic [7:0] PORT_ID;
   logic [7:0] OUT_PORT;
   logic       IO_STRB;
   logic       INT_REQ;
   logic [7:0] IN_DATA;
   logic       IN_HIT;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] sb_q[$];

   always #5 CLK = ~CLK;

   rat_int_ctrl dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .SRC      (SRC),
      .I_FLAG   (I_FLAG),
      .INT_ACK  (INT_ACK),
      .PORT_ID  (PORT_ID),
      .OUT_PORT (OUT_PORT),
      .IO_STRB  (IO_STRB),
      .INT_REQ  (INT_REQ),
      .IN_DATA  (IN_DATA),
      .IN_HIT   (IN_HIT)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic rd(input logic [7:0] port, output logic [7:0] data, output logic hit);
      PORT_ID = port;
      #1;
      data = IN_DATA;
      hit  = IN_HIT;
   endtask

   task automatic check_rd(input string tag, input logic [7:0] port, input logic [7:0] exp);
      logic [7:0] d;
      logic       h;
      rd(port, d, h);
      check(tag, d, exp);
   endtask

   task automatic io_wr(input logic [7:0] port, input logic [7:0] data);
      PORT_ID  = port;
      OUT_PORT = data;
      IO_STRB  = 1'b1;
      step();
      IO_STRB  = 1'b0;
      PORT_ID  = 8'h00;
   endtask

   task automatic pulse_src(input logic [7:0] v);
      SRC = v;
      step();
      SRC = 8'h00;
   endtask

   task automatic ack();
      INT_ACK = 1'b1;
      step();
      INT_ACK = 1'b0;
   endtask

   task automatic expect_irq(input logic [2:0] id);
      sb_q.push_back({2'b01, 3'b000, id});
   endtask

   // Wait (bounded) for INT_REQ, check latency counted from the stimulus
   // cycle, then compare the status byte with the scoreboard head.
   task automatic wait_irq(input string tag, input int start, input int exp_lat);
      int         n;
      logic [7:0] exp_stat;
      n = start;
      while (INT_REQ !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check({tag, " int_req"}, {7'b0, INT_REQ}, 8'h01);
      check({tag, " latency"}, 8'(n), 8'(exp_lat));
      exp_stat = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
      check_rd({tag, " status"}, STAT_P, exp_stat);
   endtask

   initial begin
      logic [7:0] d;
      logic       h;

      RESET    = 1'b1;
      SRC      = 8'h00;
      I_FLAG   = 1'b0;
      INT_ACK  = 1'b0;
      PORT_ID  = 8'h00;
      OUT_PORT = 8'h00;
      IO_STRB  = 1'b0;
      step();
      step();
      RESET = 1'b0;

      // Reset state
      check("rst int_req", {7'b0, INT_REQ}, 8'h00);
      check_rd("rst mask", MASK_P, 8'h00);
      check_rd("rst status", STAT_P, 8'h00);
      rd(STAT_P, d, h);
      check("rst hit stat", {7'b0, h}, 8'h01);
      rd(MASK_P, d, h);
      check("rst hit mask", {7'b0, h}, 8'h01);
      rd(EOI_P, d, h);
      check("eoi not readable hit", {7'b0, h}, 8'h00);
      check("eoi not readable data", d, 8'h00);

      // 1 Basic
      io_wr(MASK_P, 8'hFF);
      check_rd("mask readback", MASK_P, 8'hFF);
      I_FLAG = 1'b1;
      expect_irq(3'd3);
      pulse_src(8'h08);
      wait_irq("basic", 1, 3);
      ack();
      check("basic ack int_req", {7'b0, INT_REQ}, 8'h00);
      check_rd("basic ack status", STAT_P, 8'h83);
      io_wr(EOI_P, 8'h5A);
      check_rd("basic eoi status", STAT_P, 8'h03);

      // 2 Priority
      expect_irq(3'd2);
      expect_irq(3'd5);
      pulse_src(8'h24);
      wait_irq("prio first", 1, 3);
      ack();
      io_wr(EOI_P, 8'h00);
      wait_irq("prio second", 0, 2);
      ack();
      io_wr(EOI_P, 8'h00);

      // 3 Mask
      io_wr(MASK_P, 8'h00);
      pulse_src(8'h02);
      for (int i = 0; i < 5; i++) step();
      check("masked no int_req", {7'b0, INT_REQ}, 8'h00);
      check_rd("masked status", STAT_P, 8'h05);
      expect_irq(3'd1);
      io_wr(MASK_P, 8'h02);
      wait_irq("unmask", 0, 2);
      ack();
      io_wr(EOI_P, 8'h00);
      io_wr(MASK_P, 8'hFF);

      // 4 I_FLAG drop while requesting
      expect_irq(3'd4);
      pulse_src(8'h10);
      wait_irq("iflag", 1, 3);
      I_FLAG = 1'b0;
      step();
      check("iflag drop int_req", {7'b0, INT_REQ}, 8'h00);
      check_rd("iflag drop status", STAT_P, 8'h04);
      step();
      check("iflag off stays idle", {7'b0, INT_REQ}, 8'h00);
      expect_irq(3'd4);
      I_FLAG = 1'b1;
      wait_irq("iflag reenable", 0, 2);
      ack();
      io_wr(EOI_P, 8'h00);

      // ACK outside ST_REQ is ignored
      ack();
      check_rd("stray ack status", STAT_P, 8'h04);

      // 5 Set/clear collision on source 0
      expect_irq(3'd0);
      pulse_src(8'h01);
      wait_irq("collide", 1, 3);
      SRC     = 8'h01;
      INT_ACK = 1'b1;
      step();
      SRC     = 8'h00;
      INT_ACK = 1'b0;
      check("collide ack int_req", {7'b0, INT_REQ}, 8'h00);
      check_rd("collide service status", STAT_P, 8'h80);
      expect_irq(3'd0);
      io_wr(EOI_P, 8'h00);
      wait_irq("collide repend", 0, 2);
      ack();
      io_wr(EOI_P, 8'h00);

      // 6 Reset during ST_SERVICE
      expect_irq(3'd6);
      pulse_src(8'h40);
      wait_irq("rst mid", 1, 3);
      ack();
      check_rd("rst mid service", STAT_P, 8'h86);
      SRC   = 8'h40;
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      check("rst mid int_req", {7'b0, INT_REQ}, 8'h00);
      check_rd("rst mid mask", MASK_P, 8'h00);
      check_rd("rst mid status", STAT_P, 8'h00);
      for (int i = 0; i < 4; i++) step();
      check("rst masked int_req", {7'b0, INT_REQ}, 8'h00);
      expect_irq(3'd6);
      io_wr(MASK_P, 8'h40);
      wait_irq("rst unmask", 0, 2);
      SRC = 8'h00;
      ack();
      io_wr(EOI_P, 8'h00);
      check_rd("final status", STAT_P, 8'h06);
      check("scoreboard drained", 8'(sb_q.size()), 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
